// File: rtl/rob.sv
// Reorder buffer: in-order retirement of out-of-order ALU results.
// Circular buffer of RobLength+1 entries, one commit per cycle, and a full
// flush with redirect when a committing branch was mispredicted.
// Optional feature: define ROB_BYPASS_EN to let an ALU result for the head
// entry commit directly in the same cycle instead of first setting done.
module rob #(
  parameter int RobLength     = 7,
  parameter int PointerLength = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_empty_from_dc,
  input  logic [31:0] pc_from_dc,
  input  logic [4:0]  rd_from_dc,
  input  logic        is_branch_from_dc,
  input  logic [31:0] predicted_pc_from_dc,
  input  logic        is_empty_from_alu,
  input  logic [31:0] pc_from_alu,
  input  logic [31:0] data_from_alu,
  input  logic [31:0] target_pc_from_alu,
  output logic        is_ready_to_iq,
  output logic        is_commit_to_rs,
  output logic [31:0] commit_pc_to_rs,
  output logic [31:0] commit_data_to_rs,
  output logic [4:0]  commit_rd_to_rf,
  output logic        is_exception_to_rs,
  output logic [31:0] redirect_pc_to_if
);

  localparam int unsigned Depth = RobLength + 1;
  localparam int          PtrW  = PointerLength + 1;
  localparam int          CntW  = PointerLength + 2;
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(RobLength);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0] ReadyMax = CntW'(RobLength - 2);

  // Entry storage
  logic        busy_q [Depth];
  logic        done_q [Depth];
  logic        br_q   [Depth];
  logic [31:0] pc_q   [Depth];
  logic [4:0]  rd_q   [Depth];
  logic [31:0] pred_q [Depth];
  logic [31:0] data_q [Depth];
  logic [31:0] tgt_q  [Depth];

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  // Registered outputs
  logic        ready_q, commit_q, exc_q;
  logic [31:0] cpc_q, cdata_q, redir_q;
  logic [4:0]  crd_q;

  // Per-cycle control
  logic            alloc_en, wb_hit, wb_en, head_ready, bypass_hit;
  logic            commit_en, flush;
  logic [PtrW-1:0] wb_idx;
  logic [31:0]     cm_data, cm_tgt;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // Decide allocation, writeback target, commit and flush for this cycle
  always_comb begin
    alloc_en = !exc_q && !is_empty_from_dc && (count_q < DepthCnt);

    wb_hit = 1'b0;
    wb_idx = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (!wb_hit && busy_q[i] && !done_q[i] && (pc_q[i] == pc_from_alu)) begin
        wb_hit = 1'b1;
        wb_idx = PtrW'(i);
      end
    end
    wb_en = !exc_q && !is_empty_from_alu && wb_hit;

    head_ready = busy_q[head_q] && done_q[head_q];
`ifdef ROB_BYPASS_EN
    bypass_hit = wb_en && (wb_idx == head_q);
`else
    bypass_hit = 1'b0;
`endif
    commit_en = head_ready || bypass_hit;
    cm_data   = head_ready ? data_q[head_q] : data_from_alu;
    cm_tgt    = head_ready ? tgt_q[head_q]  : target_pc_from_alu;
    flush     = commit_en && br_q[head_q] && (cm_tgt != pred_q[head_q]);

    head_d  = commit_en ? ptr_inc(head_q) : head_q;
    tail_d  = alloc_en  ? ptr_inc(tail_q) : tail_q;
    count_d = count_q;
    if (alloc_en && !commit_en)      count_d = count_q + CntW'(1);
    else if (!alloc_en && commit_en) count_d = count_q - CntW'(1);

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Entry array: clear on reset/flush; otherwise allocate, write back, retire
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        busy_q[i] <= 1'b0;
        done_q[i] <= 1'b0;
        br_q[i]   <= 1'b0;
        pc_q[i]   <= '0;
        rd_q[i]   <= '0;
        pred_q[i] <= '0;
        data_q[i] <= '0;
        tgt_q[i]  <= '0;
      end
    end else begin
      if (alloc_en) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        br_q[tail_q]   <= is_branch_from_dc;
        pc_q[tail_q]   <= pc_from_dc;
        rd_q[tail_q]   <= rd_from_dc;
        pred_q[tail_q] <= predicted_pc_from_dc;
      end
      if (wb_en) begin
        done_q[wb_idx] <= 1'b1;
        data_q[wb_idx] <= data_from_alu;
        tgt_q[wb_idx]  <= target_pc_from_alu;
      end
      // Retire clears last so a bypassed head writeback does not linger
      if (commit_en) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
      end
    end
  end

  // Pointers, occupancy and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      commit_q <= 1'b0;
      exc_q    <= 1'b0;
      cpc_q    <= '0;
      cdata_q  <= '0;
      crd_q    <= '0;
      redir_q  <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ready_q  <= (count_d <= ReadyMax);
      commit_q <= commit_en;
      exc_q    <= flush;
      if (commit_en) begin
        cpc_q   <= pc_q[head_q];
        cdata_q <= cm_data;
        crd_q   <= rd_q[head_q];
      end
      if (flush) redir_q <= cm_tgt;
    end
  end

  assign is_ready_to_iq     = ready_q;
  assign is_commit_to_rs    = commit_q;
  assign commit_pc_to_rs    = cpc_q;
  assign commit_data_to_rs  = cdata_q;
  assign commit_rd_to_rf    = crd_q;
  assign is_exception_to_rs = exc_q;
  assign redirect_pc_to_if  = redir_q;

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameter RobLength, default 7, index of the last entry (RobLength+1 = 8 entries).
REQ-002 Parameter PointerLength, default 2, MSB index of the head/tail pointers (3-bit pointers).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 is_empty_from_dc  input  1  1 = no instruction offered this cycle.
REQ-006 pc_from_dc  input  32  PC of the offered instruction; also its tag, never 0.
REQ-007 rd_from_dc  input  5  destination register, 0 = none.
REQ-008 is_branch_from_dc  input  1  instruction is a branch or jump.
REQ-009 predicted_pc_from_dc  input  32  predicted next PC.
REQ-010 is_empty_from_alu  input  1  1 = no ALU result this cycle.
REQ-011 pc_from_alu  input  32  tag of the ALU result.
REQ-012 data_from_alu  input  32  result value.
REQ-013 target_pc_from_alu  input  32  resolved next PC.
REQ-014 is_ready_to_iq  output  1  1 = the ROB can accept an instruction.
REQ-015 is_commit_to_rs  output  1  one-cycle commit broadcast.
REQ-016 commit_pc_to_rs  output  32  tag of the committed entry.
REQ-017 commit_data_to_rs  output  32  value of the committed entry.
REQ-018 commit_rd_to_rf  output  5  destination register of the committed entry.
REQ-019 is_exception_to_rs  output  1  one-cycle flush; asserted on a mispredict.
REQ-020 redirect_pc_to_if  output  32  correct fetch PC; valid while is_exception_to_rs = 1.

Function
REQ-021 The ROB SHALL be a circular buffer with a head pointer, a tail pointer and an occupancy count; both pointers wrap modulo RobLength+1.
- Each entry holds busy, done, pc, rd, is_branch, predicted_pc, data and target.
REQ-022 Allocation: when is_empty_from_dc = 0 and occupancy < RobLength+1, the entry at tail SHALL be written with busy=1 and done=0, and tail SHALL advance by 1.
- When the ROB is full, the offer SHALL be dropped with no state change.
REQ-023 Writeback: when is_empty_from_alu = 0, the entry with busy=1, done=0 and pc = pc_from_alu SHALL capture data and target and set done=1.
- A writeback that matches no entry SHALL be ignored.
REQ-024 Commit: when the head entry has busy=1 and done=1, the ROB SHALL retire exactly one entry per cycle.
- The registered outputs is_commit_to_rs=1, commit_pc_to_rs, commit_data_to_rs and commit_rd_to_rf SHALL be valid in the next cycle.
- Otherwise is_commit_to_rs SHALL be 0 and the commit data outputs SHALL hold their previous values.
REQ-025 Mispredict: a committing entry with is_branch=1 and target != predicted_pc SHALL still commit (is_commit_to_rs=1). In the same registered cycle:
- is_exception_to_rs SHALL be 1 and redirect_pc_to_if SHALL equal target.
- All entries SHALL be cleared; head, tail and count SHALL be 0.
REQ-026 While is_exception_to_rs = 1, the allocation and writeback inputs SHALL be ignored.
REQ-027 Simultaneous allocate and commit SHALL leave the count unchanged.
- Allocate only SHALL increment the count; commit only SHALL decrement it.
REQ-028 is_ready_to_iq SHALL be registered: 1 when the occupancy after this cycle's updates is <= RobLength-2, else 0.
- This gives a 2-entry margin for in-flight decoder requests.
REQ-029 Commit latency SHALL be 1 cycle from writeback of the head entry to is_commit_to_rs (see REQ-033 for the exception).

Reset
REQ-030 With rst = 0 at posedge clk, all entries SHALL clear and head, tail and count SHALL be 0.
- All outputs SHALL be 0, including is_ready_to_iq.
REQ-031 is_ready_to_iq SHALL rise to 1 on the first posedge clk with rst = 1.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight entries, with no commit or exception emitted.

Configuration
REQ-033 Macro ROB_BYPASS_EN:
- Defined: an ALU writeback matching the head entry in cycle N SHALL commit from the ALU inputs directly, so is_commit_to_rs is valid in cycle N+1 without first setting done.
- Undefined: the head entry first sets done in cycle N, and is_commit_to_rs is valid no earlier than cycle N+2.

Verification
REQ-034 After reset, allocate pc 0x1000, 0x1004, 0x1008; write back 0x1004 (data 5) first, then 0x1000 (data 7).
- Commits SHALL appear in order: 0x1000/7, then 0x1004/5; nothing for 0x1008.
REQ-035 Allocate 8 entries with no writeback.
- is_ready_to_iq SHALL fall after the 6th allocation.
- A 9th offer SHALL be dropped and the count SHALL stay 8.
REQ-036 Branch at 0x2000 with predicted_pc 0x2004, ALU target 0x2040.
- In one cycle: is_commit_to_rs=1, commit_pc_to_rs=0x2000, is_exception_to_rs=1, redirect_pc_to_if=0x2040.
- Afterwards the ROB SHALL be empty and younger entries SHALL never commit.
REQ-037 Run 20 allocate/commit pairs, one of each per cycle.
- Pointers SHALL wrap past entry 7, the count SHALL stay constant and every commit PC SHALL match allocation order.
REQ-038 Pull rst low with 4 entries in flight.
- Next cycle: all outputs 0 and no commit.
- One cycle after release: is_ready_to_iq=1.
REQ-039 Write back the head entry at cycle N.
- With ROB_BYPASS_EN defined: commit at N+1.
- Without it: commit at N+2.
